// File: rtl/spi_load_ctrl.sv
// spi_load_ctrl -- serial load sequencer for the instruction and data caches.
//
// Deserialises MOSI frames ({data, addr}, MSB first) while the selected chip
// select is low. Each complete frame produces one cache write strobe. The
// strobe goes to the icache or the dcache, depending on which chip select
// opened the frame. Loading is locked out while the processor runs.
// Framing and select errors are kept in sticky flags.
//
// Optional feature: define LOAD_PARITY_EN to append one even-parity bit to
// every frame. A frame whose parity does not match is dropped and raises
// err_parity. With the macro undefined, err_parity is tied to 0.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   csi_n, csd_n        icache / dcache chip selects, active-low
//   mosi                serial data, one bit per rising edge
//   proc_run            processor executing; locks out loading
//   clr_err             clears the sticky error flags
//   wr_addr, wr_data    cache write address/data, held between frames
//   icache_wen          one-cycle icache write strobe
//   dcache_wen          one-cycle dcache write strobe
//   busy                high while a frame is being received
//   frame_cnt           committed frames, saturating
//   err_partial         sticky: frame aborted part-way
//   err_conflict        sticky: both chip selects low together
//   err_parity          sticky: parity mismatch
module spi_load_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          csi_n,
  input  logic          csd_n,
  input  logic          mosi,
  input  logic          proc_run,
  input  logic          clr_err,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          icache_wen,
  output logic          dcache_wen,
  output logic          busy,
  output logic [CW-1:0] frame_cnt,
  output logic          err_partial,
  output logic          err_conflict,
  output logic          err_parity
);

`ifdef LOAD_PARITY_EN
  localparam int FW = DW + AW + 1;
`else
  localparam int FW = DW + AW;
`endif
  localparam int BCW = $clog2(FW);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FW - 1);

  typedef enum logic [1:0] {IDLE, RECV, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           target_q, target_d;   // 0 = icache, 1 = dcache
  logic [FW-2:0]  sr_q, sr_d;           // bits received so far in this frame
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic           icache_wen_q, icache_wen_d;
  logic           dcache_wen_q, dcache_wen_d;
  logic [CW-1:0]  frame_cnt_q, frame_cnt_d;
  logic           err_partial_q, err_partial_d;
  logic           err_conflict_q, err_conflict_d;
  logic           err_parity_q, err_parity_d;

  // Event decodes produced by the next-state logic.
  logic do_start;     // first bit of a frame taken from IDLE
  logic do_sample;    // mosi is shifted in this cycle
  logic do_abort;     // frame in progress is dropped
  logic do_conflict;  // both chip selects low

  logic csi_low, csd_low, tgt_low;
  logic [FW-1:0]    frame_word;
  logic [DW+AW-1:0] payload;
  logic             last_bit, commit, parity_ok, write_en;

  assign csi_low = ~csi_n;
  assign csd_low = ~csd_n;
  assign tgt_low = target_q ? csd_low : csi_low;

  // State register (all flops).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      target_q       <= 1'b0;
      sr_q           <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      icache_wen_q   <= 1'b0;
      dcache_wen_q   <= 1'b0;
      frame_cnt_q    <= '0;
      err_partial_q  <= 1'b0;
      err_conflict_q <= 1'b0;
      err_parity_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      target_q       <= target_d;
      sr_q           <= sr_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      icache_wen_q   <= icache_wen_d;
      dcache_wen_q   <= dcache_wen_d;
      frame_cnt_q    <= frame_cnt_d;
      err_partial_q  <= err_partial_d;
      err_conflict_q <= err_conflict_d;
      err_parity_q   <= err_parity_d;
    end
  end

  // Next-state logic and event decode.
  always_comb begin
    state_d     = state_q;
    do_start    = 1'b0;
    do_sample   = 1'b0;
    do_abort    = 1'b0;
    do_conflict = 1'b0;
    case (state_q)
      IDLE: begin
        if (!proc_run) begin
          if (csi_low && csd_low) begin
            do_conflict = 1'b1;
          end else if (csi_low || csd_low) begin
            do_start  = 1'b1;
            do_sample = 1'b1;
            state_d   = RECV;
          end
        end
      end
      RECV: begin
        if (proc_run) begin
          do_abort = 1'b1;
          state_d  = LOCKED;
        end else if (csi_low && csd_low) begin
          do_abort    = 1'b1;
          do_conflict = 1'b1;
          state_d     = IDLE;
        end else if (!tgt_low) begin
          // Also covers a target swap: the new target's first bit is dropped.
          do_abort = 1'b1;
          state_d  = IDLE;
        end else begin
          do_sample = 1'b1;
        end
      end
      LOCKED: begin
        if (!proc_run && !csi_low && !csd_low) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shift register, commit, counters and error flags.
  always_comb begin
    frame_word = {sr_q, mosi};
    payload    = frame_word[FW-1 -: DW+AW];
    last_bit   = (bit_cnt_q == LAST_BIT);
    commit     = do_sample && !do_start && last_bit;
`ifdef LOAD_PARITY_EN
    parity_ok  = ~(^frame_word);
`else
    parity_ok  = 1'b1;
`endif
    write_en   = commit && parity_ok;

    target_d = do_start ? csd_low : target_q;
    sr_d     = do_sample ? frame_word[FW-2:0] : sr_q;

    bit_cnt_d = bit_cnt_q;
    if (do_start) begin
      bit_cnt_d = BCW'(1);
    end else if (do_sample) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
    end else if (do_abort) begin
      bit_cnt_d = '0;
    end

    wr_addr_d    = write_en ? payload[AW-1:0] : wr_addr_q;
    wr_data_d    = write_en ? payload[DW+AW-1:AW] : wr_data_q;
    icache_wen_d = write_en && !target_q;
    dcache_wen_d = write_en && target_q;
    frame_cnt_d  = (write_en && (frame_cnt_q != '1)) ? frame_cnt_q + 1'b1 : frame_cnt_q;

    // A new error in the same cycle as clr_err keeps the flag set.
    err_partial_d  = (err_partial_q & ~clr_err) | (do_abort && (bit_cnt_q != '0));
    err_conflict_d = (err_conflict_q & ~clr_err) | do_conflict;
`ifdef LOAD_PARITY_EN
    err_parity_d   = (err_parity_q & ~clr_err) | (commit && !parity_ok);
`else
    err_parity_d   = 1'b0;
`endif
  end

  // Outputs.
  always_comb begin
    busy         = (state_q == RECV);
    wr_addr      = wr_addr_q;
    wr_data      = wr_data_q;
    icache_wen   = icache_wen_q;
    dcache_wen   = dcache_wen_q;
    frame_cnt    = frame_cnt_q;
    err_partial  = err_partial_q;
    err_conflict = err_conflict_q;
    err_parity   = err_parity_q;
  end

endmodule

// File: tb/tb_spi_load_ctrl.sv
module tb_spi_load_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 8;
`ifdef LOAD_PARITY_EN
  localparam int FW = DW + AW + 1;
`else
  localparam int FW = DW + AW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csi_n = 1'b1, csd_n = 1'b1, mosi = 1'b0, proc_run = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          icache_wen, dcache_wen, busy;
  logic [CW-1:0] frame_cnt;
  logic          err_partial, err_conflict, err_parity;

  spi_load_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi),
    .proc_run(proc_run), .clr_err(clr_err), .wr_addr(wr_addr), .wr_data(wr_data),
    .icache_wen(icache_wen), .dcache_wen(dcache_wen), .busy(busy),
    .frame_cnt(frame_cnt), .err_partial(err_partial), .err_conflict(err_conflict),
    .err_parity(err_parity)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tgt;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   wen_times[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (icache_wen || dcache_wen)) begin
      exp_t e;
      wen_times.push_back(cyc);
      if (icache_wen && dcache_wen) check("wen_exclusive", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_wen", {30'd0, dcache_wen, icache_wen}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wen_target", {31'd0, dcache_wen}, {31'd0, e.tgt});
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
        $display("write tgt=%0d addr=%0h data=%0h cyc=%0d", dcache_wen, wr_addr, wr_data, cyc);
      end
    end
  end

  // Drive one cycle of inputs; return just after the sampling edge.
  task automatic tick(input logic ci, input logic cd, input logic m, input logic pr, input logic cl);
    csi_n = ci; csd_n = cd; mosi = m; proc_run = pr; clr_err = cl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Send a full frame on the chosen target; expectation pushed when driven.
  task automatic send_frame(input logic tgt, input logic [DW-1:0] d, input logic [AW-1:0] a,
                            input logic bad_parity);
    logic [FW-1:0] w;
    exp_t e;
`ifdef LOAD_PARITY_EN
    w = {d, a, (^{d, a}) ^ bad_parity};
`else
    w = {d, a};
`endif
    if (!bad_parity) begin
      e.tgt = tgt; e.a = a; e.d = d;
      sb.push_back(e);
      exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
    end
    for (int i = FW - 1; i >= 0; i--) tick(tgt, ~tgt, w[i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW+AW-1:0] w12;
    int t0;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wen", {30'd0, icache_wen, dcache_wen}, 32'd0);
    check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    check("rst_err", {29'd0, err_partial, err_conflict, err_parity}, 32'd0);
    check("rst_wr", {20'd0, wr_data, wr_addr}, 32'd0);

    // 1: single icache frame, wen visible in the cycle after the last bit
    send_frame(1'b0, 8'hA5, 4'h3, 1'b0);
    check("t1_wen_latency", {31'd0, icache_wen}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    idle(1);
    check("t1_wen_one_cycle", {31'd0, icache_wen}, 32'd0);
    check("t1_cnt", {24'd0, frame_cnt}, exp_cnt);
    check("t1_err", {29'd0, err_partial, err_conflict, err_parity}, 32'd0);
    idle(1);

    // 2: back-to-back dcache frames, strobes FW cycles apart
    wen_times.delete();
    send_frame(1'b1, 8'h7E, 4'hF, 1'b0);
    send_frame(1'b1, 8'h01, 4'h0, 1'b0);
    idle(2);
    check("t2_nstrobes", wen_times.size(), 32'd2);
    if (wen_times.size() == 2) check("t2_gap", wen_times[1] - wen_times[0], FW);
    check("t2_cnt", {24'd0, frame_cnt}, exp_cnt);
    check("t2_held_addr", {28'd0, wr_addr}, 32'h0);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // 3: partial dcache frame
    w12 = {8'h55, 4'hA};
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, w12[DW+AW-1-i], 1'b0, 1'b0);
    idle(1);
    check("t3_err_partial", {31'd0, err_partial}, 32'd1);
    check("t3_cnt", {24'd0, frame_cnt}, exp_cnt);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3_clr", {31'd0, err_partial}, 32'd0);

    // 4: both selects low from IDLE
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_conflict", {31'd0, err_conflict}, 32'd1);
    // clr_err with a new conflict in the same cycle: new error wins
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t4_clr_vs_new", {31'd0, err_conflict}, 32'd1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_clr", {31'd0, err_conflict}, 32'd0);

    // 4b: conflict mid-frame aborts and flags both errors
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4b_busy", {31'd0, busy}, 32'd0);
    check("t4b_errs", {30'd0, err_partial, err_conflict}, 32'd3);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // 5: proc_run at bit 5, then lockout while CS stays low
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, w12[DW+AW-1-i], 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_partial", {31'd0, err_partial}, 32'd1);
    for (int i = 0; i < FW; i++) tick(1'b0, 1'b1, w12[i % (DW+AW)], 1'b0, 1'b0);
    check("t5_locked", {31'd0, busy}, 32'd0);
    check("t5_cnt", {24'd0, frame_cnt}, exp_cnt);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h3C, 4'h9, 1'b0);
    idle(1);
    check("t5_cnt_after", {24'd0, frame_cnt}, exp_cnt);

    // 6: parity
`ifdef LOAD_PARITY_EN
    send_frame(1'b0, 8'hA5, 4'h3, 1'b1);
    idle(1);
    check("t6_err_parity", {31'd0, err_parity}, 32'd1);
    check("t6_held_data", {24'd0, wr_data}, 32'h3C);
    send_frame(1'b0, 8'hA5, 4'h3, 1'b0);
    idle(1);
`else
    check("t6_parity_off", {31'd0, err_parity}, 32'd0);
`endif
    check("t6_cnt", {24'd0, frame_cnt}, exp_cnt);

    // Random back-to-back frames up to and past counter saturation
    t0 = exp_cnt;
    for (int i = 0; i < (1 << CW) + 2 - t0; i++) begin
      logic tg;
      tg = 1'(i % 2);
      if (i % 8 == 7) idle(1);
      send_frame(tg, DW'($urandom), AW'($urandom), 1'b0);
      idle(1);
    end
    idle(2);
    check("sat_cnt", {24'd0, frame_cnt}, exp_cnt);
    check("sat_value", {24'd0, frame_cnt}, (1 << CW) - 1);

    // Reset mid-frame: no strobe, everything cleared
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    csi_n = 1'b1;
    exp_cnt = 0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cnt", {24'd0, frame_cnt}, exp_cnt);
    idle(FW + 2);
    check("midrst_nowen", {30'd0, icache_wen, dcache_wen}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
